// File: rtl/expr_seq_ctrl.sv
// rtl/expr_seq_ctrl.sv - evaluates max(a,b) + max(floor, bias - 5*|a-b|) on one shared ALU
// One evaluation in flight; the FSM issues one ALU op per cycle.
module expr_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_bias,
  input  logic [WIDTH-1:0] in_floor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy,
  output logic [2:0]       alu_op
);

  typedef enum logic [2:0] {
    IDLE, S_MAX, S_DIFF, S_MUL, S_SUB, S_FLR, S_ADD, DONE
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MAX  = 3'd1;
  localparam logic [2:0] OP_ABSD = 3'd2;
  localparam logic [2:0] OP_MUL5 = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;

  state_t state, state_nxt;

  logic [WIDTH-1:0] ra, rb, rbias, rfloor, r_max, r_t;
  logic             ovf;

  logic [WIDTH-1:0] alu_x, alu_y, alu_res;
  logic             alu_cy;
  logic [WIDTH+2:0] prod;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alu_op    = OP_NOP;
    alu_x     = '0;
    alu_y     = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_MAX;
      end
      S_MAX:  begin alu_op = OP_MAX;  alu_x = ra;     alu_y = rb;  state_nxt = S_DIFF; end
      S_DIFF: begin alu_op = OP_ABSD; alu_x = ra;     alu_y = rb;  state_nxt = S_MUL;  end
      S_MUL:  begin alu_op = OP_MUL5; alu_x = r_t;                 state_nxt = S_SUB;  end
      S_SUB:  begin alu_op = OP_SUB;  alu_x = rbias;  alu_y = r_t; state_nxt = S_FLR;  end
      S_FLR:  begin alu_op = OP_MAX;  alu_x = rfloor; alu_y = r_t; state_nxt = S_ADD;  end
      S_ADD:  begin alu_op = OP_ADD;  alu_x = r_max;  alu_y = r_t; state_nxt = DONE;   end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared ALU: alu_cy flags a wrap (mul overflow, sub borrow, add carry).
  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    prod    = ({3'b000, alu_x} << 2) + {3'b000, alu_x};
    sum     = {1'b0, alu_x} + {1'b0, alu_y};
    case (alu_op)
      OP_MAX:  alu_res = (alu_x > alu_y) ? alu_x : alu_y;
      OP_ABSD: alu_res = (alu_x > alu_y) ? (alu_x - alu_y) : (alu_y - alu_x);
      OP_MUL5: begin
        alu_res = prod[WIDTH-1:0];
        alu_cy  = |prod[WIDTH+2:WIDTH];
      end
      OP_SUB: begin
        alu_res = alu_x - alu_y;
        alu_cy  = alu_y > alu_x;
      end
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_cy  = sum[WIDTH];
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra       <= '0;
      rb       <= '0;
      rbias    <= '0;
      rfloor   <= '0;
      r_max    <= '0;
      r_t      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra     <= in_a;
            rb     <= in_b;
            rbias  <= in_bias;
            rfloor <= in_floor;
            ovf    <= 1'b0;
          end
        end
        S_MAX: r_max <= alu_res;
        S_DIFF, S_MUL, S_SUB, S_FLR: begin
          r_t <= alu_res;
          ovf <= ovf | alu_cy;
        end
        S_ADD: begin
          out_data <= alu_res;
          out_ovf  <= ovf | alu_cy;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_seq_ctrl.sv
// tb/tb_expr_seq_ctrl.sv - directed bench for expr_seq_ctrl with a cycle-level reference model
// Inputs change at posedge+1; all checks sample at negedge.
module tb_expr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0, in_b = '0, in_bias = '0, in_floor = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       busy;
  logic [2:0] alu_op;

  int vectors = 0;
  int errs = 0;

  expr_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_bias(in_bias), .in_floor(in_floor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf),
    .busy(busy), .alu_op(alu_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Straight arithmetic from the expression; returns {ovf, result}.
  function automatic int model(input int a, input int b, input int bias, input int fl);
    int m, d, p, t, s, sum;
    bit o;
    m = (a > b) ? a : b;
    d = (a > b) ? a - b : b - a;
    p = 5 * d;
    o = (p >= 256);
    t = p % 256;
    o = o | (t > bias);
    s = (bias - t + 256) % 256;
    if (fl > s) s = fl;
    sum = m + s;
    o = o | (sum >= 256);
    return (int'(o) << 8) | (sum % 256);
  endfunction

  // Cycle-level expectations: 0 idle, 1 sequencing (phase 1..6), 2 result pending.
  int mode = 0, phase = 0, last_data = 0, exp_d = 0, exp_o = 0;
  int op_tbl [6] = '{1, 2, 3, 4, 1, 5};

  always @(negedge clk) begin
    case (mode)
      0: begin
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_alu_op", alu_op, 0);
        chk("idle_out_data", out_data, last_data);
      end
      1: begin
        chk("seq_alu_op", alu_op, op_tbl[phase-1]);
        chk("seq_in_ready", in_ready, 0);
        chk("seq_busy", busy, 1);
        chk("seq_out_valid", out_valid, 0);
        chk("seq_out_data_held", out_data, last_data);
      end
      default: begin
        chk("done_out_valid", out_valid, 1);
        chk("done_in_ready", in_ready, 0);
        chk("done_busy", busy, 1);
        chk("done_alu_op", alu_op, 0);
        chk("done_out_data", out_data, exp_d);
        chk("done_out_ovf", out_ovf, exp_o);
      end
    endcase
    if (rst) begin
      mode = 0;
      last_data = 0;
    end else begin
      case (mode)
        0: if (in_valid) begin
          int r;
          r = model(in_a, in_b, in_bias, in_floor);
          exp_d = r & 255;
          exp_o = r >> 8;
          mode = 1;
          phase = 1;
        end
        1: if (phase == 6) begin
          mode = 2;
          last_data = exp_d;
        end else phase++;
        default: if (out_ready) mode = 0;
      endcase
    end
  end

  task automatic wait_valid(input string name, output int k);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (out_valid) begin k = i; break; end
    end
    if (k == 0) chk({name, "_timeout"}, 0, 1);
  endtask

  // Starts and ends at posedge+1 with the DUT idle; out_ready held high.
  task automatic run_op(input int a, input int b, input int bias, input int fl,
                        input int ed, input int eo, input string name, input bit chk_lat);
    int k;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 8'(a); in_b = 8'(b); in_bias = 8'(bias); in_floor = 8'(fl);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_bias = 8'($urandom); in_floor = 8'($urandom);
    wait_valid(name, k);
    if (chk_lat) chk({name, "_latency"}, k, 7);
    chk({name, "_data"}, out_data, ed);
    chk({name, "_ovf"}, out_ovf, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    chk("model_pin_24", model(1, 1, 23, 0), 24);
    chk("model_pin_235", model(200, 100, 23, 0), 256 + 235);

    run_op(1, 1, 23, 0, 24, 0, "eq", 1'b1);
    run_op(1, 0, 23, 0, 19, 0, "ops", 1'b1);
    run_op(200, 100, 23, 0, 235, 1, "wrap", 1'b1);
    run_op(10, 4, 40, 50, 60, 0, "floor", 1'b1);
    run_op(250, 250, 23, 0, 17, 1, "carry", 1'b1);
    run_op(0, 255, 0, 255, 254, 1, "edge", 1'b0);

    // Backpressure in DONE with a competing in_valid.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 8'd10; in_b = 8'd4; in_bias = 8'd40; in_floor = 8'd50;
    @(negedge clk);
    @(posedge clk); #1;
    in_a = 8'd1; in_b = 8'd1; in_bias = 8'd23; in_floor = 8'd0;
    wait_valid("bp", k);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 60);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_back_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("bp2", k);
    chk("bp2_data", out_data, 24);
    @(posedge clk); #1;

    // Reset while in S_MUL discards the evaluation.
    in_valid = 1'b1;
    in_a = 8'd200; in_b = 8'd100; in_bias = 8'd23; in_floor = 8'd0;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_busy", busy, 0);
    @(posedge clk); #1;
    run_op(1, 0, 23, 0, 19, 0, "post_rst", 1'b1);

    for (int i = 0; i < 6; i++) begin
      int a, b, bias, fl, r;
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      bias = $urandom_range(0, 255); fl = $urandom_range(0, 255);
      r = model(a, b, bias, fl);
      run_op(a, b, bias, fl, r & 255, r >> 8, "rand", 1'b1);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/expr_seq_ctrl.md
Name: expr_seq_ctrl

Overview:
- Multi-cycle controller that evaluates result = max(a,b) + max(floor, bias - 5*|a-b|) on one shared ALU instead of six parallel operator blocks.
- The shared ALU supports max, absdiff, mul5, sub and add.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides.
- One evaluation is in flight at a time; the FSM steps the ALU through one operation per cycle.

Parameters:
- WIDTH, 8, operand/result width; all arithmetic is unsigned modulo 2^WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set offered
- in_ready  output  1  controller can accept operands (IDLE only)
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_bias  input  WIDTH  bias term
- in_floor  input  WIDTH  lower clamp term
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  result
- out_ovf  output  1  sticky: some wrap occurred during this evaluation
- busy  output  1  high in any state other than IDLE
- alu_op  output  3  op issued this cycle: 0 NOP, 1 MAX, 2 ABSDIFF, 3 MUL5, 4 SUB, 5 ADD

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, busy=0, alu_op=0. All internal registers are cleared.
- States, in order: IDLE, S_MAX, S_DIFF, S_MUL, S_SUB, S_FLR, S_ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, b, bias and floor, clear the ovf accumulator, go to S_MAX.
- S_MAX: alu_op=1; r_max <= max(a,b), unsigned compare (equal selects b).
- S_DIFF: alu_op=2; r_t <= |a-b|, always non-negative, no wrap.
- S_MUL:
  - alu_op=3; r_t <= (5*r_t) mod 2^WIDTH.
  - ovf |= (5*r_t >= 2^WIDTH).
- S_SUB:
  - alu_op=4; r_t <= (bias - r_t) mod 2^WIDTH.
  - ovf |= (r_t > bias), i.e. a borrow occurred.
- S_FLR: alu_op=1; r_t <= max(floor, r_t), on the wrapped unsigned value.
- S_ADD:
  - alu_op=5; out_data <= (r_max + r_t) mod 2^WIDTH.
  - ovf |= carry out; out_ovf <= final ovf. Go to DONE.
- Each of S_MAX..S_ADD lasts exactly one cycle. There are no stalls inside the sequence.
- DONE:
  - out_valid=1; alu_op=0.
  - out_data and out_ovf are held stable until out_ready is sampled high.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE.
- Latency: accept at edge T; out_valid is high from cycle T+7.
- Throughput: one result per 8 cycles minimum (DONE -> IDLE -> accept).
- in_ready=0 in DONE: no same-cycle result handoff plus new accept.
- out_data keeps its last value after the handoff until the next S_ADD. Only out_valid qualifies it.
- Operand ports are ignored except at the accept edge; changing them mid-sequence has no effect.
- in_valid while busy is ignored and not queued. The source must hold it until in_ready.
- rst mid-sequence or in DONE: the next edge forces the reset values. A pending result is discarded.
- rst has priority over every handshake in the same cycle.

Test Plan:
- a=1, b=1, bias=23, floor=0 -> out_data=24, out_ovf=0; out_valid rises exactly 7 cycles after the accept edge.
- a=1, b=0, bias=23, floor=0 -> out_data=19, out_ovf=0; alu_op sequence 1,2,3,4,1,5 then 0.
- a=200, b=100, bias=23, floor=0 -> mul wraps to 244, sub wraps to 35 -> out_data=235, out_ovf=1.
- a=10, b=4, bias=40, floor=50 -> floor clamp selected -> out_data=60, out_ovf=0. Separately, a=250, b=250, bias=23, floor=0 -> add carry -> out_data=17, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_data and out_ovf stay stable and in_ready stays 0. A new in_valid pulse during DONE is not accepted. With out_ready=1 -> IDLE next cycle, then the next op is accepted.
- Assert rst during S_MUL -> next cycle state is IDLE, in_ready=1, out_valid=0, out_data=0, busy=0. A fresh evaluation of 1,0,23,0 then yields 19.
